// File: rtl/alu_defs.sv
// Shared definitions for the ALU command sequencer: opcode values, the
// legal-opcode check and the sequencer FSM state encoding.
package alu_defs;

    localparam logic [3:0] OP_ADDC = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_FUNC = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_e;

    function automatic logic opcode_is_legal(input logic [3:0] op);
        return (op inside {OP_ADDC, OP_ADD, OP_SUB, OP_NAND, OP_OR,
                           OP_XOR, OP_NOT, OP_SRL, OP_FUNC});
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-issuing front end for the 4-bit ALU: registers a command, drives the
// ALU for one cycle, captures its result and hands it out over valid/ready.
module alu_cmd_sequencer
    import alu_defs::*;
#(
    parameter int WIDTH = 4,
    parameter int OPW   = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_use_acc,
    input  logic             cmd_use_carry,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_of,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_of,
    output logic             res_err,
    output logic [CNTW-1:0]  op_count,
    output logic [CNTW-1:0]  err_count
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             alu_cin_q, alu_cin_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_cout_q, res_cout_d, res_of_q, res_of_d, res_err_q, res_err_d;
    logic [CNTW-1:0]  op_count_q, op_count_d, err_count_q, err_count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_cin_q   <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_of_q    <= 1'b0;
            res_err_q   <= 1'b0;
            op_count_q  <= '0;
            err_count_q <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_of_q    <= res_of_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
            err_count_q <= err_count_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_cin_d   = alu_cin_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        res_of_d    = res_of_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;
        err_count_d = err_count_q;
        acc_d       = acc_q;
        carry_d     = carry_q;

        // Gated by reset so cmd_ready reads 0 while reset is held.
        cmd_ready = !reset && ((state_q == ST_IDLE) ||
                               ((state_q == ST_HOLD) && res_ready));
        accept    = cmd_valid && cmd_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
                if (opcode_is_legal(alu_op_q)) begin
                    res_data_d = alu_out;
                    res_cout_d = alu_cout;
                    res_of_d   = alu_of;
                    res_err_d  = 1'b0;
                    acc_d      = alu_out;
                    carry_d    = alu_cout;
                end else begin
                    res_data_d  = '0;
                    res_cout_d  = 1'b0;
                    res_of_d    = 1'b0;
                    res_err_d   = 1'b1;
                    err_count_d = err_count_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = accept ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accepts only happen in IDLE or HOLD, one cycle after any capture,
        // so acc_q/carry_q already hold the freshest chained values here.
        if (accept) begin
            alu_a_d   = cmd_use_acc   ? acc_q   : cmd_a;
            alu_b_d   = cmd_b;
            alu_op_d  = cmd_op;
            alu_cin_d = cmd_use_carry ? carry_q : cmd_cin;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = alu_cin_q;
    assign res_valid = (state_q == ST_HOLD);
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign res_of    = res_of_q;
    assign res_err   = res_err_q;
    assign op_count  = op_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU model closes the
// loop, a directed table plus random commands are checked against a chaining model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_cin, cmd_use_acc, cmd_use_carry;
    logic [3:0] cmd_op, cmd_a, cmd_b;
    logic [3:0] alu_a, alu_b, alu_op, alu_out;
    logic       alu_cin, alu_cout, alu_of;
    logic       res_valid, res_ready, res_cout, res_of, res_err;
    logic [3:0] res_data;
    logic [7:0] op_count, err_count;
    logic [5:0] aluRes;

    int nChecks = 0;
    int nErrors = 0;

    logic [3:0] modelAcc;
    logic       modelCarry;
    int         modelOps, modelErrs;

    typedef struct {
        logic [3:0] op, a, b;
        logic       cin, ua, uc;
        logic [3:0] expA;
        logic       expCin;
        logic [3:0] expData;
        logic       expCout, expOf, expErr;
        int         delay;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .cmd_use_acc(cmd_use_acc), .cmd_use_carry(cmd_use_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_of(alu_of),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_of(res_of), .res_err(res_err),
        .op_count(op_count), .err_count(err_count)
    );

    // Behavioural 4-bit ALU; illegal opcodes return deliberate junk so the
    // sequencer's zeroing of illegal results is observable.
    function automatic logic [5:0] aluCalc(input logic [3:0] op, a, b, input logic cin);
        logic [4:0] s;
        logic       of;
        s  = '0;
        of = 1'b0;
        case (op)
            4'b0001: begin
                s  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                of = (a[3] == b[3]) && (s[3] != a[3]);
            end
            4'b0010: begin
                s  = {1'b0, a} + {1'b0, b};
                of = (a[3] == b[3]) && (s[3] != a[3]);
            end
            4'b0011: begin
                s  = {1'b0, a} + {1'b0, ~b} + 5'd1;
                of = (a[3] != b[3]) && (s[3] != a[3]);
            end
            4'b0100: s = {1'b0, ~(a & b)};
            4'b0101: s = {1'b0, a | b};
            4'b0110: s = {1'b0, a ^ b};
            4'b0111: s = {1'b0, ~a};
            4'b1000: s = {a[0], 1'b0, a[3:1]};
            4'b1111: s = {1'b0, a[2:0], a[3]};
            default: begin
                s  = {1'b1, a ^ b ^ 4'b0101};
                of = 1'b1;
            end
        endcase
        return {of, s};
    endfunction

    always_comb aluRes = aluCalc(alu_op, alu_a, alu_b, alu_cin);
    assign alu_out  = aluRes[3:0];
    assign alu_cout = aluRes[4];
    assign alu_of   = aluRes[5];

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: resolve operand muxes, apply the ALU, update chaining state.
    task automatic modelStep(input vec_t vin, output vec_t vout);
        logic [5:0] r;
        vout        = vin;
        vout.expA   = vin.ua ? modelAcc : vin.a;
        vout.expCin = vin.uc ? modelCarry : vin.cin;
        if (alu_defs::opcode_is_legal(vin.op)) begin
            r            = aluCalc(vin.op, vout.expA, vin.b, vout.expCin);
            vout.expData = r[3:0];
            vout.expCout = r[4];
            vout.expOf   = r[5];
            vout.expErr  = 1'b0;
            modelAcc     = r[3:0];
            modelCarry   = r[4];
        end else begin
            vout.expData = 4'd0;
            vout.expCout = 1'b0;
            vout.expOf   = 1'b0;
            vout.expErr  = 1'b1;
            modelErrs++;
        end
        modelOps++;
    endtask

    task automatic driveCmd(input vec_t v);
        cmd_op        = v.op;
        cmd_a         = v.a;
        cmd_b         = v.b;
        cmd_cin       = v.cin;
        cmd_use_acc   = v.ua;
        cmd_use_carry = v.uc;
        cmd_valid     = 1'b1;
    endtask

    // Entered just after a negedge with the sequencer idle; leaves it idle.
    task automatic applyStimulus(input vec_t v, input string tag);
        checkOutput({tag, " cmd_ready idle"}, cmd_ready, 1);
        driveCmd(v);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, " alu_a"}, alu_a, v.expA);
        checkOutput({tag, " alu_b"}, alu_b, v.b);
        checkOutput({tag, " alu_op"}, alu_op, v.op);
        checkOutput({tag, " alu_cin"}, alu_cin, v.expCin);
        checkOutput({tag, " issue res_valid"}, res_valid, 0);
        @(negedge clk);
        checkOutput({tag, " res_valid"}, res_valid, 1);
        checkOutput({tag, " res_data"}, res_data, v.expData);
        checkOutput({tag, " res_cout"}, res_cout, v.expCout);
        checkOutput({tag, " res_of"}, res_of, v.expOf);
        checkOutput({tag, " res_err"}, res_err, v.expErr);
        for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            checkOutput({tag, " stall res_valid"}, res_valid, 1);
            checkOutput({tag, " stall res_data"}, res_data, v.expData);
            checkOutput({tag, " stall res_err"}, res_err, v.expErr);
            checkOutput({tag, " stall cmd_ready"}, cmd_ready, 0);
        end
        res_ready = 1'b1;
        #1 checkOutput({tag, " hold cmd_ready"}, cmd_ready, 1);
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, " done res_valid"}, res_valid, 0);
        checkOutput({tag, " op_count"}, op_count, modelOps % 256);
        checkOutput({tag, " err_count"}, err_count, modelErrs % 256);
    endtask

    initial begin
        vec_t v, m, v2, m2;

        //        op      a      b      cin ua uc expA   cin  data   co of err dly
        vecs[0] = '{4'b0010, 4'd3, 4'd3, 0, 0, 0, 4'd3,  0, 4'b0110, 0, 0, 0, 0};
        vecs[1] = '{4'b0001, 4'd6, 4'd5, 1, 0, 0, 4'd6,  1, 4'b1100, 0, 1, 0, 1};
        vecs[2] = '{4'b0011, 4'd7, 4'd6, 0, 0, 0, 4'd7,  0, 4'b0001, 1, 0, 0, 0};
        vecs[3] = '{4'b0010, 4'd9, 4'd2, 0, 1, 0, 4'd1,  0, 4'b0011, 0, 0, 0, 2};
        vecs[4] = '{4'b0010, 4'hF, 4'd1, 0, 0, 0, 4'hF,  0, 4'b0000, 1, 0, 0, 0};
        vecs[5] = '{4'b0001, 4'd0, 4'd0, 0, 0, 1, 4'd0,  1, 4'b0001, 0, 0, 0, 0};
        vecs[6] = '{4'b1010, 4'd5, 4'd5, 0, 0, 0, 4'd5,  0, 4'b0000, 0, 0, 1, 5};
        vecs[7] = '{4'b0001, 4'd7, 4'd0, 1, 1, 1, 4'd1,  0, 4'b0001, 0, 0, 0, 0};
        vecs[8] = '{4'b1000, 4'd9, 4'd0, 0, 0, 0, 4'd9,  0, 4'b0100, 1, 0, 0, 1};

        modelAcc = '0; modelCarry = 0; modelOps = 0; modelErrs = 0;
        cmd_valid = 0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 0;
        cmd_use_acc = 0; cmd_use_carry = 0; res_ready = 0;
        reset = 1'b1;
        #12;
        checkOutput("reset cmd_ready", cmd_ready, 0);
        checkOutput("reset res_valid", res_valid, 0);
        checkOutput("reset alu_a", alu_a, 0);
        checkOutput("reset op_count", op_count, 0);
        @(negedge clk) reset = 1'b0;
        #1 checkOutput("release cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 9; i++) begin
            modelStep(vecs[i], m);
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end
        checkOutput("table err_count", err_count, 1);
        checkOutput("table op_count", op_count, 9);

        // Back-to-back: chained command accepted in the same cycle as the handshake.
        v  = '{4'b0011, 4'd7, 4'd6, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0};
        v2 = '{4'b0010, 4'd9, 4'd2, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0};
        modelStep(v, m);
        modelStep(v2, m2);
        driveCmd(v);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b first res_data", res_data, 4'd1);
        driveCmd(v2);
        res_ready = 1'b1;
        #1 checkOutput("b2b cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 begin cmd_valid = 1'b0; res_ready = 1'b0; end
        @(negedge clk);
        checkOutput("b2b alu_a", alu_a, 4'd1);
        checkOutput("b2b issue res_valid", res_valid, 0);
        @(negedge clk);
        checkOutput("b2b res_valid", res_valid, 1);
        checkOutput("b2b res_data", res_data, 4'd3);
        res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        checkOutput("b2b idle res_valid", res_valid, 0);
        checkOutput("b2b op_count", op_count, modelOps % 256);

        for (int i = 0; i < 40; i++) begin
            v.op    = 4'($urandom_range(0, 15));
            v.a     = 4'($urandom_range(0, 15));
            v.b     = 4'($urandom_range(0, 15));
            v.cin   = 1'($urandom_range(0, 1));
            v.ua    = 1'($urandom_range(0, 1));
            v.uc    = 1'($urandom_range(0, 1));
            v.delay = $urandom_range(0, 2);
            modelStep(v, m);
            applyStimulus(m, $sformatf("rnd%0d", i));
        end

        // Reset while the command is in ISSUE: everything clears asynchronously.
        v = '{4'b0010, 4'hA, 4'd3, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0};
        driveCmd(v);
        @(posedge clk); #1 cmd_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async alu_a", alu_a, 0);
        checkOutput("async alu_b", alu_b, 0);
        checkOutput("async alu_cin", alu_cin, 0);
        checkOutput("async res_valid", res_valid, 0);
        checkOutput("async cmd_ready", cmd_ready, 0);
        checkOutput("async op_count", op_count, 0);
        checkOutput("async err_count", err_count, 0);
        @(negedge clk) reset = 1'b0;
        modelAcc = '0; modelCarry = 0; modelOps = 0; modelErrs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post-reset res_valid", res_valid, 0);
            checkOutput("post-reset cmd_ready", cmd_ready, 1);
        end
        v = '{4'b0001, 4'd5, 4'd1, 0, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0, 0};
        modelStep(v, m);
        applyStimulus(m, "post-reset acc");
        checkOutput("post-reset acc data", res_data, 4'd1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
